// File: rtl/oc8051_prog_mem_if.sv
// Fetch-side, external-bus and array-load signals of the oc8051 program memory.
// The slave modport is the memory's view; master is the view of the core/bench driving it.
interface oc8051_prog_mem_if #(
  parameter int ADDR_WID    = 16,
  parameter int INT_ROM_WID = 7,
  parameter int FETCH_BYTES = 3
) ();
  logic                     ea_n;
  logic                     req;
  logic [ADDR_WID-1:0]      addr;
  logic                     valid;
  logic [8*FETCH_BYTES-1:0] data;
  logic                     busy;
  logic                     ea_int;
  logic [ADDR_WID-1:0]      ext_addr;
  logic                     ext_rd;
  logic [7:0]               ext_data;
  logic                     ext_ack;
  logic                     ld_we;
  logic [INT_ROM_WID-1:0]   ld_addr;
  logic [7:0]               ld_data;

  modport slave (
    input  ea_n, req, addr, ext_data, ext_ack, ld_we, ld_addr, ld_data,
    output valid, data, busy, ea_int, ext_addr, ext_rd
  );

  modport master (
    output ea_n, req, addr, ext_data, ext_ack, ld_we, ld_addr, ld_data,
    input  valid, data, busy, ea_int, ext_addr, ext_rd
  );
endinterface

// File: rtl/oc8051_prog_mem.sv
// oc8051 program memory: returns FETCH_BYTES opcode bytes per request, from a run-time
// loadable on-chip array for the low region or byte by byte over a handshaked external bus.
module oc8051_prog_mem #(
  parameter int ADDR_WID    = 16,
  parameter int INT_ROM_WID = 7,
  parameter int FETCH_BYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  oc8051_prog_mem_if.slave  bus
);

  localparam int         DW       = 8 * FETCH_BYTES;
  localparam logic [1:0] LAST_IDX = 2'(FETCH_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_INT, S_EXT, S_DONE} state_e;

  state_e              r_state;
  logic [ADDR_WID-1:0] r_addr;
  logic [ADDR_WID-1:0] r_ext_addr;
  logic [1:0]          r_idx;
  logic                r_ext_rd;
  logic                r_valid;
  logic                r_busy;
  logic [DW-1:0]       r_data;
  logic [DW-1:0]       r_stage;
  logic [7:0]          r_mem [2**INT_ROM_WID];

  logic                w_int_path;
  logic [DW-1:0]       w_int_window;
  logic [DW-1:0]       w_stage_next;

  // Internal only if the whole window, computed one bit wider so a wrap can't sneak in.
  assign w_int_path = bus.ea_n &&
    (({1'b0, bus.addr} + (ADDR_WID+1)'(FETCH_BYTES - 1)) < ((ADDR_WID+1)'(1) << INT_ROM_WID));

  assign bus.ea_int = (bus.addr[ADDR_WID-1:INT_ROM_WID] == '0) && bus.ea_n;

  always_comb begin
    w_int_window = '0;
    w_stage_next = r_stage;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      w_int_window[8*k +: 8] = r_mem[r_addr[INT_ROM_WID-1:0] + INT_ROM_WID'(k)];
      if (r_idx == 2'(k)) w_stage_next[8*k +: 8] = bus.ext_data;
    end
  end

  // NOTE: the code array has no reset, so its contents survive rst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (bus.ld_we) r_mem[bus.ld_addr] <= bus.ld_data;
  end

  // NOTE: non-blocking writes make an INT read and a load of the same byte read-first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_ext_addr <= '0;
      r_idx      <= '0;
      r_ext_rd   <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_data     <= '0;
      r_stage    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_addr <= bus.addr;
            r_busy <= 1'b1;
            r_idx  <= '0;
            if (w_int_path) begin
              r_state <= S_INT;
            end else begin
              r_state    <= S_EXT;
              r_ext_rd   <= 1'b1;
              r_ext_addr <= bus.addr;
            end
          end
        end
        S_INT: begin
          r_data  <= w_int_window;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_EXT: begin
          if (bus.ext_ack) begin
            r_stage <= w_stage_next;
            if (r_idx == LAST_IDX) begin
              r_ext_rd <= 1'b0;
              r_data   <= w_stage_next;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_ext_addr <= r_addr + ADDR_WID'(r_idx) + ADDR_WID'(1);
            end
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid    = r_valid;
  assign bus.data     = r_data;
  assign bus.busy     = r_busy;
  assign bus.ext_addr = r_ext_addr;
  assign bus.ext_rd   = r_ext_rd;

endmodule

// File: tb/tb_oc8051_prog_mem.sv
// Directed bench for oc8051_prog_mem: stimulus pushes the expected window into a queue,
// a negedge monitor pops and compares on every valid pulse.
module tb_oc8051_prog_mem;

  localparam int AW = 16;
  localparam int IW = 7;
  localparam int FB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [8*FB-1:0] exp_q [$];
  logic [8*FB-1:0] mon_exp;

  oc8051_prog_mem_if #(.ADDR_WID(AW), .INT_ROM_WID(IW), .FETCH_BYTES(FB)) bus ();

  oc8051_prog_mem #(.ADDR_WID(AW), .INT_ROM_WID(IW), .FETCH_BYTES(FB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {8'h00, bus.data}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("fetch_data", {8'h00, bus.data}, {8'h00, mon_exp});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] a, input logic [7:0] d);
    bus.ld_we   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick();
    bus.ld_we   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic issue_req(input logic [AW-1:0] a, input logic ea_n,
                           input logic [8*FB-1:0] exp, input bit push);
    wait_idle();
    bus.ea_n = ea_n;
    bus.addr = a;
    bus.req  = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    bus.req  = 1'b0;
  endtask

  task automatic serve_ext(input logic [AW-1:0] a0, input logic [8*FB-1:0] bytes, input int waits);
    logic [AW-1:0] ea;
    for (int k = 0; k < FB; k++) begin
      ea = a0 + AW'(k);
      for (int w = 0; w < waits; w++) begin
        check("ext_rd_wait", {31'd0, bus.ext_rd}, 32'd1);
        check("ext_addr_wait", {16'd0, bus.ext_addr}, {16'd0, ea});
        tick();
      end
      check("ext_rd", {31'd0, bus.ext_rd}, 32'd1);
      check("ext_addr", {16'd0, bus.ext_addr}, {16'd0, ea});
      bus.ext_ack  = 1'b1;
      bus.ext_data = bytes[8*k +: 8];
      tick();
      bus.ext_ack  = 1'b0;
      bus.ext_data = 8'h00;
    end
    check("ext_rd_done", {31'd0, bus.ext_rd}, 32'd0);
    check("valid_ext", {31'd0, bus.valid}, 32'd1);
  endtask

  initial begin
    bus.ea_n = 1'b1; bus.req = 1'b0; bus.addr = '0;
    bus.ext_data = '0; bus.ext_ack = 1'b0;
    bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    #1;
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ext_rd", {31'd0, bus.ext_rd}, 32'd0);
    check("rst_data", {8'h00, bus.data}, 32'd0);
    check("rst_ext_addr", {16'd0, bus.ext_addr}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Internal fetch, latency and busy window
    load(7'd0, 8'h02); load(7'd1, 8'h00); load(7'd2, 8'h35); load(7'd3, 8'h7E);
    load(7'd5, 8'h11); load(7'd6, 8'h01); load(7'd7, 8'h02);
    bus.ext_ack = 1'b1;
    tick();
    bus.ext_ack = 1'b0;
    check("stray_ack_busy", {31'd0, bus.busy}, 32'd0);
    check("stray_ack_rd", {31'd0, bus.ext_rd}, 32'd0);
    issue_req(16'h0000, 1'b1, 24'h350002, 1'b1);
    check("int_busy1", {31'd0, bus.busy}, 32'd1);
    check("int_valid1", {31'd0, bus.valid}, 32'd0);
    check("int_rd1", {31'd0, bus.ext_rd}, 32'd0);
    tick();
    check("int_busy2", {31'd0, bus.busy}, 32'd1);
    check("int_valid2", {31'd0, bus.valid}, 32'd1);
    check("int_rd2", {31'd0, bus.ext_rd}, 32'd0);
    tick();
    check("int_busy3", {31'd0, bus.busy}, 32'd0);
    check("int_valid3", {31'd0, bus.valid}, 32'd0);

    // External fetch with one wait state per byte
    issue_req(16'h0100, 1'b1, 24'hCCBBAA, 1'b1);
    serve_ext(16'h0100, 24'hCCBBAA, 1);
    tick();
    check("ext_valid_once", {31'd0, bus.valid}, 32'd0);

    // Boundary straddle goes external, zero wait states; array left intact
    issue_req(16'h007F, 1'b1, 24'h332211, 1'b1);
    serve_ext(16'h007F, 24'h332211, 0);
    issue_req(16'h0000, 1'b1, 24'h350002, 1'b1);
    tick(); tick();

    // ea_int decode and forced external access
    wait_idle();
    bus.addr = 16'h0003; bus.ea_n = 1'b1; #1;
    check("ea_int_low", {31'd0, bus.ea_int}, 32'd1);
    bus.addr = 16'h0080; #1;
    check("ea_int_high", {31'd0, bus.ea_int}, 32'd0);
    bus.addr = 16'h0003; bus.ea_n = 1'b0; #1;
    check("ea_int_ea_n", {31'd0, bus.ea_int}, 32'd0);
    issue_req(16'h0003, 1'b0, 24'h665544, 1'b1);
    serve_ext(16'h0003, 24'h665544, 0);
    issue_req(16'hFFFF, 1'b1, 24'h998877, 1'b1);
    serve_ext(16'hFFFF, 24'h998877, 2);
    tick();

    // Reset in the middle of an external fetch
    issue_req(16'h0200, 1'b1, 24'h000000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      bus.ext_ack = 1'b1; bus.ext_data = 8'hE0 + 8'(k);
      tick();
    end
    bus.ext_ack = 1'b0;
    check("pre_rst_addr", {16'd0, bus.ext_addr}, 32'h0202);
    rst = 1'b0;
    #1;
    check("mid_rst_rd", {31'd0, bus.ext_rd}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    check("mid_rst_data", {8'h00, bus.data}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    issue_req(16'h0001, 1'b1, 24'h7E3500, 1'b1);
    tick(); tick();

    // Load colliding with an internal read is read-first
    issue_req(16'h0005, 1'b1, 24'h020111, 1'b1);
    bus.ld_we = 1'b1; bus.ld_addr = 7'd5; bus.ld_data = 8'h22;
    tick();
    bus.ld_we = 1'b0;
    tick();
    issue_req(16'h0005, 1'b1, 24'h020122, 1'b1);
    tick(); tick();

    wait_idle();
    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
